// File: rtl/buffer_read_controller_filter_mc.sv
// Streams NUM_FILTERS consecutive filters from the filter buffer into per-filter
// scratchpads, one word per accepted cycle, with a mode-scaled and clamped filter length.
module buffer_read_controller_filter_mc #(
    parameter int SPAD_ADDR_WIDTH   = 4,
    parameter int SPAD_DEPTH        = 16,
    parameter int FILTER_SIZE_WIDTH = 3,
    parameter int NUM_FILTERS       = 4,
    parameter int FIDX_WIDTH        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
    input  logic                         r_next_filter,
    input  logic                         valid,
    input  logic                         stall,
    input  logic                         clr_addr,
    output logic                         ren_buf,
    output logic [NUM_FILTERS-1:0]       wen_spad,
    output logic [SPAD_ADDR_WIDTH-1:0]   spad_waddr,
    output logic [FIDX_WIDTH-1:0]        filter_idx,
    output logic                         valid_end,
    output logic                         done
);

    // Length arithmetic must hold both the scaled size and SPAD_DEPTH itself.
    localparam int CW   = FILTER_SIZE_WIDTH + 2;
    localparam int DW   = $clog2(SPAD_DEPTH + 1);
    localparam int LW   = (CW > DW) ? CW : DW;
    localparam int CMPW = (LW > SPAD_ADDR_WIDTH) ? LW : SPAD_ADDR_WIDTH;
    localparam logic [FIDX_WIDTH-1:0] LAST_FIDX = FIDX_WIDTH'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [1:0]                   r_mode;
    logic [1:0]                   w_mode_nxt;
    logic [FILTER_SIZE_WIDTH-1:0] r_fsize;
    logic [FILTER_SIZE_WIDTH-1:0] w_fsize_nxt;
    logic [SPAD_ADDR_WIDTH-1:0]   r_spad_waddr;
    logic [SPAD_ADDR_WIDTH-1:0]   w_waddr_nxt;
    logic [FIDX_WIDTH-1:0]        r_filter_idx;
    logic [FIDX_WIDTH-1:0]        w_fidx_nxt;

    logic [LW-1:0]                w_len;
    logic [LW-1:0]                w_start_len;
    logic                         w_accept;
    logic                         w_last_word;

    function automatic logic [LW-1:0] eff_len(input logic [1:0] m,
                                              input logic [FILTER_SIZE_WIDTH-1:0] fs);
        logic [LW-1:0] scaled;
        case (m)
            2'd2:    scaled = LW'(fs) << 1;
            2'd3:    scaled = LW'(fs) << 2;
            default: scaled = LW'(fs);
        endcase
        if (scaled > LW'(SPAD_DEPTH)) begin
            eff_len = LW'(SPAD_DEPTH);
        end else begin
            eff_len = scaled;
        end
    endfunction

    assign w_len       = eff_len(r_mode, r_fsize);
    assign w_start_len = eff_len(mode, filter_size);
    assign w_accept    = (r_state == S_READ) && valid && !stall;
    assign w_last_word = (CMPW'(r_spad_waddr) == (CMPW'(w_len) - CMPW'(1)));

    // Next-state, counter and config update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_fsize_nxt = r_fsize;
        w_waddr_nxt = r_spad_waddr;
        w_fidx_nxt  = r_filter_idx;
        if (clr_addr) begin
            w_state_nxt = S_IDLE;
            w_mode_nxt  = 2'd0;
            w_fsize_nxt = '0;
            w_waddr_nxt = '0;
            w_fidx_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_next_filter) begin
                        w_mode_nxt  = mode;
                        w_fsize_nxt = filter_size;
                        w_waddr_nxt = '0;
                        w_fidx_nxt  = '0;
                        // A zero-length request skips the transfer phase entirely.
                        if (w_start_len == LW'(0)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_READ;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_READ: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            w_waddr_nxt = '0;
                            if (r_filter_idx == LAST_FIDX) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_fidx_nxt = r_filter_idx + FIDX_WIDTH'(1);
                            end
                        end else begin
                            w_waddr_nxt = r_spad_waddr + SPAD_ADDR_WIDTH'(1);
                        end
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and config registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode       <= 2'd0;
            r_fsize      <= '0;
            r_spad_waddr <= '0;
            r_filter_idx <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_fsize      <= w_fsize_nxt;
            r_spad_waddr <= w_waddr_nxt;
            r_filter_idx <= w_fidx_nxt;
        end
    end

    // Zero-latency strobes decoded from the current state and handshake inputs.
    always_comb begin
        ren_buf  = 1'b0;
        wen_spad = '0;
        if (w_accept) begin
            ren_buf  = 1'b1;
            wen_spad = NUM_FILTERS'(1) << r_filter_idx;
        end else begin
            ren_buf  = 1'b0;
            wen_spad = '0;
        end
    end

    assign spad_waddr = r_spad_waddr;
    assign filter_idx = r_filter_idx;
    assign valid_end  = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule

// File: doc/buffer_read_controller_filter_mc.md
# buffer_read_controller_filter_mc

Multi-filter successor of the single-filter buffer read controller. On a start request it streams `NUM_FILTERS` consecutive filters from the filter buffer into per-filter scratchpads, one word per accepted cycle. Each filter length is `filter_size` scaled by mode and clamped to the scratchpad depth. It sits between the filter buffer (read side) and the PE filter scratchpads (write side), under the PE-array main controller.

## Interface
- `SPAD_ADDR_WIDTH`, 4, scratchpad address width
- `SPAD_DEPTH`, 16, scratchpad words per filter; must be ≤ 2^SPAD_ADDR_WIDTH and ≥ 1
- `FILTER_SIZE_WIDTH`, 3, width of `filter_size`
- `NUM_FILTERS`, 4, filters loaded per request; ≥ 1
- `FIDX_WIDTH`, 2, filter index width; must satisfy 2^FIDX_WIDTH ≥ NUM_FILTERS
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  length scale: 0,1 → ×1; 2 → ×2; 3 → ×4
- `filter_size`  in  FILTER_SIZE_WIDTH  base filter length in words
- `r_next_filter`  in  1  start request, sampled in IDLE only
- `valid`  in  1  buffer word available this cycle
- `stall`  in  1  downstream stall; freezes transfer
- `clr_addr`  in  1  synchronous abort/clear
- `ren_buf`  out  1  buffer read strobe (word consumed)
- `wen_spad`  out  NUM_FILTERS  one-hot scratchpad write enable
- `spad_waddr`  out  SPAD_ADDR_WIDTH  scratchpad write address
- `filter_idx`  out  FIDX_WIDTH  filter currently being loaded
- `valid_end`  out  1  controller idle, ready for a request
- `done`  out  1  one-cycle pulse after the last word of the last filter

## Operation
- States: IDLE, READ, DONE.
- IDLE: `valid_end`=1. On `r_next_filter`=1, latch `mode` and `filter_size` into config registers, clear `spad_waddr` and `filter_idx`, and go to READ. Unless stated otherwise, changes to `mode` and `filter_size` after this point are ignored until the next start.
- Effective length L = latched `filter_size` << {0,0,1,2}[mode], computed at FILTER_SIZE_WIDTH+2 bits. Then L = min(L, SPAD_DEPTH).
- If L = 0 at start, go straight to DONE. No reads or writes occur.
- READ: a word is accepted when `valid` && !`stall`. The outputs in that cycle are:
  - `ren_buf`=1;
  - `wen_spad` = one-hot(`filter_idx`);
  - `spad_waddr` = current address.
- After each accepted word:
  - if `spad_waddr` < L-1, increment `spad_waddr`;
  - otherwise wrap `spad_waddr` to 0 and increment `filter_idx`;
  - if that word was the last word of filter NUM_FILTERS-1, go to DONE instead.
- With `valid`=0 or `stall`=1, all strobes are 0 and the counters hold.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `valid_end`=0 in DONE.
- A `r_next_filter` arriving in READ or DONE is ignored (it is not queued).
- `clr_addr`=1: next state is IDLE, and `spad_waddr`, `filter_idx` and config are zeroed. It overrides `r_next_filter` and any accepted transfer. Outputs in the `clr_addr` cycle remain combinational from the current state, so a strobe may still fire.
- Priority: `rst` > `clr_addr` > start/transfer.

## Timing
- All state changes occur on the rising edge of `clk`. All strobes are combinational from state, `valid`, and `stall`, with zero latency.
- Reset values: state IDLE, `valid_end`=1, `done`=0, `ren_buf`=0, `wen_spad`=0, `spad_waddr`=0, `filter_idx`=0.
- Start latency: the request cycle is spent in IDLE, and the first possible write occurs in the next cycle.
- Minimum total duration is 1 + NUM_FILTERS·L + 1 cycles (IDLE request, transfers, DONE). Each stall or invalid cycle adds one cycle.
- Back-to-back operation: `r_next_filter` held high through DONE starts a new load in the cycle after DONE, i.e. the first IDLE cycle.
- `rst` asserted mid-READ takes effect at the next edge. No further strobes occur after that edge.

## Test plan
- Basic load: mode=0, filter_size=3, NUM_FILTERS=4, valid=1, stall=0. Expect 12 writes with addresses 0,1,2 per filter, `wen_spad` sequence 0001,0010,0100,1000, then `done` one cycle later and `valid_end` the cycle after that.
- Mode scaling and clamp: filter_size=5. With mode=2, expect L=10 and address wraps after 9. With mode=3, L=20 is clamped to 16, so addresses run 0..15 and the last address per filter is 15.
- Zero length: filter_size=0 with a start request. Expect DONE in the next cycle, `done` pulse, and no `ren_buf` or `wen_spad` activity.
- Stall/valid gaps: mode=0, filter_size=2, with `stall` high on cycles 2–3 and `valid` low on cycle 5. Expect no strobes or counter movement in those cycles, the same write sequence as without gaps, and total duration extended by 3 cycles.
- Abort: assert `clr_addr` mid-filter 1 at address 2. Expect IDLE on the next cycle with `spad_waddr`=0 and `filter_idx`=0. A following `r_next_filter` then restarts from filter 0.
- Reset mid-READ and ignored request: `r_next_filter` pulsed during READ has no effect. `rst` during READ yields all reset values on the next cycle.
